// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM and ALU decoder for the multicycle MIPS datapath
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alu_control
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t r_state;
  logic w_pcwrite, w_branch;
  logic [1:0] w_aluop;
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else case (r_state)
      FETCH:   r_state <= DECODE;
      DECODE:  r_state <= (op == OP_LW || op == OP_SW) ? MEMADR :
                          op == OP_R    ? RTYPEEX :
                          op == OP_BEQ  ? BEQEX :
                          op == OP_ADDI ? ADDIEX :
                          op == OP_J    ? JEX : FETCH;
      MEMADR:  r_state <= (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   r_state <= MEMWB;
      RTYPEEX: r_state <= ALUWB;
      ADDIEX:  r_state <= ADDIWB;
      default: r_state <= FETCH;
    endcase
  end
  // Reset suppresses every output, so no write enable can fire while it is held
  always_comb begin
    iord = 1'b0;
    memwrite = 1'b0;
    irwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    w_pcwrite = 1'b0;
    w_branch = 1'b0;
    w_aluop = 2'b00;
    if (!reset) case (r_state)
      FETCH:   begin irwrite = 1'b1; w_pcwrite = 1'b1; alusrcb = 2'b01; end
      DECODE:  alusrcb = 2'b11;
      MEMADR,
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; w_aluop = 2'b10; end
      ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; end
      ADDIWB:  regwrite = 1'b1;
      BEQEX:   begin alusrca = 1'b1; w_aluop = 2'b01; pcsrc = 2'b01; w_branch = 1'b1; end
      JEX:     begin pcsrc = 2'b10; w_pcwrite = 1'b1; end
      default: ;
    endcase
    pcen = w_pcwrite | (w_branch & zero);
    alu_control = w_aluop == 2'b01 ? 3'b110 :
                  w_aluop != 2'b10 ? 3'b010 :
                  funct == 6'b100010 ? 3'b110 :
                  funct == 6'b100100 ? 3'b000 :
                  funct == 6'b100101 ? 3'b001 :
                  funct == 6'b101010 ? 3'b111 : 3'b010;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed stimulus with a queued scoreboard checked by a separate monitor
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'b0, funct = 6'b0;
  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alu_control;
  int checks = 0, fails = 0;
  typedef struct { logic [14:0] v; string nm; } exp_t;
  exp_t sb[$];
  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alu_control}
  localparam logic [14:0] E_RST   = 15'b0_0_0_0_0_0_0_00_00_0_010;
  localparam logic [14:0] E_FETCH = 15'b0_0_1_0_0_0_0_01_00_1_010;
  localparam logic [14:0] E_DEC   = 15'b0_0_0_0_0_0_0_11_00_0_010;
  localparam logic [14:0] E_ADR   = 15'b0_0_0_0_0_0_1_10_00_0_010;
  localparam logic [14:0] E_MRD   = 15'b1_0_0_0_0_0_0_00_00_0_010;
  localparam logic [14:0] E_MWB   = 15'b0_0_0_0_1_1_0_00_00_0_010;
  localparam logic [14:0] E_MWR   = 15'b1_1_0_0_0_0_0_00_00_0_010;
  localparam logic [14:0] E_SLT   = 15'b0_0_0_0_0_0_1_00_00_0_111;
  localparam logic [14:0] E_AND   = 15'b0_0_0_0_0_0_1_00_00_0_000;
  localparam logic [14:0] E_OR    = 15'b0_0_0_0_0_0_1_00_00_0_001;
  localparam logic [14:0] E_SUB   = 15'b0_0_0_0_0_0_1_00_00_0_110;
  localparam logic [14:0] E_RADD  = 15'b0_0_0_0_0_0_1_00_00_0_010;
  localparam logic [14:0] E_AWB   = 15'b0_0_0_1_0_1_0_00_00_0_010;
  localparam logic [14:0] E_BEQ1  = 15'b0_0_0_0_0_0_1_00_01_1_110;
  localparam logic [14:0] E_BEQ0  = 15'b0_0_0_0_0_0_1_00_01_0_110;
  localparam logic [14:0] E_IWB   = 15'b0_0_0_0_0_1_0_00_00_0_010;
  localparam logic [14:0] E_JEX   = 15'b0_0_0_0_0_0_0_00_10_1_010;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alu_control(alu_control)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rs, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [14:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rs; op = o; funct = f; zero = z;
    x.v = e; x.nm = nm;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      logic [14:0] got;
      x = sb.pop_front();
      got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alu_control};
      checks++;
      if (got !== x.v) begin
        fails++;
        $display("FAIL %s: got %b expected %b", x.nm, got, x.v);
      end
    end
  end

  initial begin
    step(1, LW, 0, 0, E_RST, "por_rst0");
    step(1, LW, 0, 0, E_RST, "por_rst1");
    step(0, LW, 0, 0, E_FETCH, "pre_fetch");
    step(0, LW, 0, 0, E_DEC, "pre_decode");
    step(0, LW, 0, 1, E_ADR, "pre_memadr");
    step(1, LW, 0, 1, E_RST, "rst_hold0");
    step(1, LW, 0, 1, E_RST, "rst_hold1");
    step(1, LW, 0, 1, E_RST, "rst_hold2");
    // lw
    step(0, LW, 0, 0, E_FETCH, "lw_fetch");
    step(0, LW, 0, 0, E_DEC, "lw_decode");
    step(0, LW, 0, 0, E_ADR, "lw_memadr");
    step(0, LW, 0, 0, E_MRD, "lw_memrd");
    step(0, LW, 0, 0, E_MWB, "lw_memwb");
    // sw
    step(0, SW, 0, 0, E_FETCH, "sw_fetch");
    step(0, SW, 0, 0, E_DEC, "sw_decode");
    step(0, SW, 0, 0, E_ADR, "sw_memadr");
    step(0, SW, 0, 0, E_MWR, "sw_memwr");
    // R-type: slt, and, or, sub, add, unknown funct
    step(0, RT, 6'b101010, 0, E_FETCH, "slt_fetch");
    step(0, RT, 6'b101010, 0, E_DEC, "slt_decode");
    step(0, RT, 6'b101010, 0, E_SLT, "slt_ex");
    step(0, RT, 6'b101010, 0, E_AWB, "slt_wb");
    step(0, RT, 6'b100100, 0, E_FETCH, "and_fetch");
    step(0, RT, 6'b100100, 0, E_DEC, "and_decode");
    step(0, RT, 6'b100100, 0, E_AND, "and_ex");
    step(0, RT, 6'b100100, 0, E_AWB, "and_wb");
    step(0, RT, 6'b100101, 0, E_FETCH, "or_fetch");
    step(0, RT, 6'b100101, 0, E_DEC, "or_decode");
    step(0, RT, 6'b100101, 0, E_OR, "or_ex");
    step(0, RT, 6'b100101, 0, E_AWB, "or_wb");
    step(0, RT, 6'b100010, 0, E_FETCH, "sub_fetch");
    step(0, RT, 6'b100010, 0, E_DEC, "sub_decode");
    step(0, RT, 6'b100010, 0, E_SUB, "sub_ex");
    step(0, RT, 6'b100010, 0, E_AWB, "sub_wb");
    step(0, RT, 6'b100000, 0, E_FETCH, "add_fetch");
    step(0, RT, 6'b100000, 0, E_DEC, "add_decode");
    step(0, RT, 6'b100000, 0, E_RADD, "add_ex");
    step(0, RT, 6'b100000, 0, E_AWB, "add_wb");
    step(0, RT, 6'b111000, 0, E_FETCH, "rdef_fetch");
    step(0, RT, 6'b111000, 0, E_DEC, "rdef_decode");
    step(0, RT, 6'b111000, 0, E_RADD, "rdef_ex");
    step(0, RT, 6'b111000, 0, E_AWB, "rdef_wb");
    // beq taken / not taken
    step(0, BEQ, 0, 0, E_FETCH, "beq1_fetch");
    step(0, BEQ, 0, 0, E_DEC, "beq1_decode");
    step(0, BEQ, 0, 1, E_BEQ1, "beq1_ex");
    step(0, BEQ, 0, 1, E_FETCH, "beq0_fetch");
    step(0, BEQ, 0, 1, E_DEC, "beq0_decode");
    step(0, BEQ, 0, 0, E_BEQ0, "beq0_ex");
    // addi, j, undefined
    step(0, ADDI, 0, 0, E_FETCH, "addi_fetch");
    step(0, ADDI, 0, 0, E_DEC, "addi_decode");
    step(0, ADDI, 0, 1, E_ADR, "addi_ex");
    step(0, ADDI, 0, 1, E_IWB, "addi_wb");
    step(0, J, 0, 0, E_FETCH, "j_fetch");
    step(0, J, 0, 0, E_DEC, "j_decode");
    step(0, J, 0, 1, E_JEX, "j_ex");
    step(0, BAD, 0, 0, E_FETCH, "bad_fetch");
    step(0, BAD, 0, 1, E_DEC, "bad_decode");
    // reset aborts in MEMWR and ALUWB
    step(0, SW, 0, 0, E_FETCH, "swr_fetch");
    step(0, SW, 0, 0, E_DEC, "swr_decode");
    step(0, SW, 0, 0, E_ADR, "swr_memadr");
    step(1, SW, 0, 0, E_RST, "swr_rst_in_memwr");
    step(0, RT, 6'b101010, 0, E_FETCH, "rtr_fetch");
    step(0, RT, 6'b101010, 0, E_DEC, "rtr_decode");
    step(0, RT, 6'b101010, 0, E_SLT, "rtr_ex");
    step(1, RT, 6'b101010, 0, E_RST, "rtr_rst_in_aluwb");
    step(0, LW, 0, 0, E_FETCH, "final_fetch");
    step(0, LW, 0, 0, E_DEC, "final_decode");
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the 32-bit multicycle MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, and it decodes opcode/funct into the 3-bit ALU operation consumed by the ALU. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26], from instruction register
- funct  in  6  instruction[5:0], from instruction register
- zero  in  1  ALU zero flag, same cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  write data select: 0 = ALUOut, 1 = memory data
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- alu_control  out  3  ALU operation code

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE:
    - lw or sw -> MEMADR
    - R-type -> RTYPEEX
    - beq -> BEQEX
    - addi -> ADDIEX
    - j -> JEX
    - any other opcode -> FETCH (executes as NOP; the PC has already advanced).
  - MEMADR: lw -> MEMRD; sw -> MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQEX and JEX -> FETCH.
- Per-state outputs. Every output not listed for a state is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00 (branch target precompute).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - JEX: pcsrc=10, pcwrite=1.
- ALU decode (combinational from the internal aluop and funct):
  - aluop=00 -> 010 (add).
  - aluop=01 -> 110 (sub).
  - aluop=10, by funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - any other funct -> 010 (add).
- All outputs are a function of state plus op/funct/zero only. No output depends on any other input.

## Timing
- State register updates on the rising edge of clk. Outputs are combinational from the current state.
- The only Mealy term is pcen in BEQEX, which follows zero in the same cycle.
- Reset, while asserted:
  - memwrite, irwrite, regwrite and pcen are forced to 0 regardless of state.
  - All other outputs are 0, except alu_control = 010.
  - The state register loads FETCH on the next clock edge.
- Reset asserted mid-instruction aborts the instruction at the next edge. No write enable is asserted in the cycle reset is high.
- The first cycle after reset deasserts is FETCH.
- Instruction latency in cycles, FETCH included:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - undefined opcode 2
- op and funct are sampled in DECODE and later states. The instruction register is stable because irwrite is asserted only in FETCH.
- Back-to-back instructions: the cycle after any terminal state is FETCH. There are no idle cycles.

## Test plan
- Reset held 3 cycles in a random state, then released -> enables stay 0 throughout, first post-reset state is FETCH with irwrite=1, pcen=1, alusrcb=01, alu_control=010.
- lw (op 100011) -> 5-cycle sequence FETCH/DECODE/MEMADR/MEMRD/MEMWB. MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0. Next cycle is FETCH.
- sw then R-type funct 101010 -> sw: MEMWR with memwrite=1, iord=1, regwrite never 1. Slt: RTYPEEX alu_control=111, then ALUWB regwrite=1, regdst=1. Each takes 4 cycles.
- beq with zero=1, then beq with zero=0 -> BEQEX alu_control=110, pcsrc=01 in both. pcen=1 only in the zero=1 case. Each takes 3 cycles.
- addi, then j (000010), then undefined op 111111 -> addi: ADDIEX alusrcb=10 and ADDIWB regwrite=1, regdst=0. j: JEX pcsrc=10, pcen=1. Undefined op: DECODE -> FETCH with no write enable asserted.
- Reset asserted in MEMWR and in ALUWB -> memwrite/regwrite are 0 in that cycle, state is FETCH after the edge.
